// File: rtl/tcp_rx_ctrl_if.sv
// Nibble-stream receive interface from the IP layer into the TCP sequencer.
// Latency: n/a (wires only).
// Backpressure: none; the producer qualifies nibbles with valid and may insert gaps freely.
interface tcp_rx_ctrl_if;
  logic        valid;
  logic [3:0]  din;
  logic        last;
  logic [15:0] seed;

  modport master (output valid, output din, output last, output seed);
  modport slave  (input  valid, input  din, input  last, input  seed);
endinterface

// File: rtl/tcp_rx_ctrl.sv
// TCP receive sequencer: walks a nibble stream through header/options/payload, checksums it, reports pass/drop.
// Latency: hdr_valid/pl_valid one cycle after the completing nibble; done one cycle after the last nibble.
// Backpressure: none; valid-only stream, and cycles with valid low freeze every register.
module tcp_rx_ctrl #(
  parameter logic [15:0] LOCAL_PORT    = 16'd80,
  parameter int          MAX_OPT_BYTES = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  tcp_rx_ctrl_if.slave rx,
  output logic [15:0]  src_port,
  output logic [15:0]  dst_port,
  output logic [31:0]  seq_num,
  output logic [31:0]  ack_num,
  output logic [8:0]   flags,
  output logic [15:0]  window,
  output logic         hdr_valid,
  output logic [7:0]   pl_data,
  output logic         pl_valid,
  output logic         done,
  output logic         csum_ok,
  output logic         drop,
  output logic [1:0]   err
);
  localparam int OPT_W = $clog2(MAX_OPT_BYTES + 1);

  typedef enum logic [2:0] {IDLE, HDR, OPT, PAYLOAD, SKIP} state_t;
  state_t state, state_nxt;

  logic             phase;      // 1 = next nibble completes a byte
  logic [3:0]       lo_nib;
  logic [7:0]       hi_byte;    // even-indexed byte awaiting its odd partner
  logic [15:0]      byte_cnt;   // completed bytes in this segment
  logic [15:0]      acc;        // folded ones-complement running sum
  logic [3:0]       offset;
  logic [OPT_W-1:0] opt_rem;
  logic             err2_flag;

  logic [7:0]  cur_byte;
  logic        byte_fire, at_hdr_end, hdr_fire, err2_now, pl_fire, seg_end, short_seg;
  logic [15:0] acc_base, acc_pair, fin_sum;
  logic [1:0]  err_now;

  // 16-bit add with the carry out of bit 15 wrapped back into bit 0.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Per-nibble decode: byte completion, header boundary events and end-of-segment status.
  always_comb begin
    cur_byte   = {rx.din, lo_nib};
    byte_fire  = rx.valid && phase;
    at_hdr_end = byte_fire && (state == HDR) && (byte_cnt == 16'd19);
    hdr_fire   = (at_hdr_end && (offset == 4'd5)) ||
                 (byte_fire && (state == OPT) && (opt_rem == OPT_W'(1)));
    err2_now   = at_hdr_end && (offset < 4'd5);
    pl_fire    = byte_fire && (state == PAYLOAD) && (dst_port == LOCAL_PORT);
    seg_end    = rx.valid && rx.last;
    // The first nibble of a segment sees the seed, since acc is loaded only as it is consumed.
    acc_base   = (state == IDLE) ? rx.seed : acc;
    acc_pair   = oc_add(acc_base, {hi_byte, cur_byte});
    fin_sum    = acc_base;
    if (byte_fire)
      fin_sum = byte_cnt[0] ? acc_pair : oc_add(acc_base, {cur_byte, 8'h00});
    else if (byte_cnt[0])
      fin_sum = oc_add(acc_base, {hi_byte, 8'h00});
    short_seg  = ((state == HDR) && !(at_hdr_end && (offset <= 4'd5))) ||
                 ((state == OPT) && !hdr_fire);
    err_now    = 2'd0;
    if (!phase)                      err_now = 2'd3;
    else if (short_seg)              err_now = 2'd1;
    else if (err2_flag || err2_now)  err_now = 2'd2;
  end

  // Next-state logic: last always returns to IDLE, otherwise advance at phase boundaries.
  always_comb begin
    state_nxt = state;
    if (seg_end) begin
      state_nxt = IDLE;
    end else if (rx.valid) begin
      case (state)
        IDLE: state_nxt = HDR;
        HDR: begin
          if (at_hdr_end) begin
            if (offset < 4'd5)      state_nxt = SKIP;
            else if (offset > 4'd5) state_nxt = OPT;
            else                    state_nxt = PAYLOAD;
          end
        end
        OPT:     if (hdr_fire) state_nxt = PAYLOAD;
        default: state_nxt = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Nibble assembly, byte counting, checksum accumulation and option countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      lo_nib    <= 4'd0;
      hi_byte   <= 8'd0;
      byte_cnt  <= 16'd0;
      acc       <= 16'd0;
      opt_rem   <= '0;
      err2_flag <= 1'b0;
    end else if (rx.valid) begin
      if (rx.last) begin
        phase     <= 1'b0;
        byte_cnt  <= 16'd0;
        err2_flag <= 1'b0;
      end else begin
        phase <= ~phase;
        if (!phase) lo_nib <= rx.din;
        if (state == IDLE) begin
          byte_cnt <= 16'd0;
          acc      <= rx.seed;
        end
        if (byte_fire) begin
          byte_cnt <= byte_cnt + 16'd1;
          if (byte_cnt[0]) acc     <= acc_pair;
          else             hi_byte <= cur_byte;
        end
        if (at_hdr_end)
          opt_rem <= OPT_W'({2'b00, offset, 2'b00} - 8'd20);
        else if (byte_fire && (state == OPT))
          opt_rem <= opt_rem - OPT_W'(1);
        if (err2_now) err2_flag <= 1'b1;
      end
    end
  end

  // Header bytes land directly in the field outputs, which persist until the next header rewrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_port <= 16'd0;
      dst_port <= 16'd0;
      seq_num  <= 32'd0;
      ack_num  <= 32'd0;
      flags    <= 9'd0;
      window   <= 16'd0;
      offset   <= 4'd0;
    end else if (byte_fire && (state == HDR)) begin
      case (byte_cnt)
        16'd0:   src_port[15:8] <= cur_byte;
        16'd1:   src_port[7:0]  <= cur_byte;
        16'd2:   dst_port[15:8] <= cur_byte;
        16'd3:   dst_port[7:0]  <= cur_byte;
        16'd4:   seq_num[31:24] <= cur_byte;
        16'd5:   seq_num[23:16] <= cur_byte;
        16'd6:   seq_num[15:8]  <= cur_byte;
        16'd7:   seq_num[7:0]   <= cur_byte;
        16'd8:   ack_num[31:24] <= cur_byte;
        16'd9:   ack_num[23:16] <= cur_byte;
        16'd10:  ack_num[15:8]  <= cur_byte;
        16'd11:  ack_num[7:0]   <= cur_byte;
        16'd12: begin
          offset   <= cur_byte[7:4];
          flags[8] <= cur_byte[0];
        end
        16'd13:  flags[7:0]     <= cur_byte;
        16'd14:  window[15:8]   <= cur_byte;
        16'd15:  window[7:0]    <= cur_byte;
        default: ;
      endcase
    end
  end

  // Registered event outputs: header strobe, payload bytes and the end-of-segment verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_valid <= 1'b0;
      pl_valid  <= 1'b0;
      pl_data   <= 8'd0;
      done      <= 1'b0;
      csum_ok   <= 1'b0;
      drop      <= 1'b0;
      err       <= 2'd0;
    end else begin
      hdr_valid <= hdr_fire;
      pl_valid  <= pl_fire;
      if (pl_fire) pl_data <= cur_byte;
      done <= seg_end;
      if (seg_end) begin
        csum_ok <= (fin_sum == 16'hFFFF);
        drop    <= (dst_port != LOCAL_PORT) || (err_now != 2'd0) || (fin_sum != 16'hFFFF);
        err     <= err_now;
      end else begin
        csum_ok <= 1'b0;
        drop    <= 1'b0;
        err     <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Self-checking bench for tcp_rx_ctrl: directed cases plus randomized segments against a byte-level model.
// Latency: outputs sampled on the falling edge; verdicts checked a few cycles after each last nibble.
// Backpressure: none; stimulus inserts optional valid gaps between nibbles.
module tb_tcp_rx_ctrl;
  typedef struct packed {logic ok; logic drop; logic [1:0] err;} done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] src_port, dst_port, window;
  logic [31:0] seq_num, ack_num;
  logic [8:0]  flags;
  logic        hdr_valid, pl_valid, done, csum_ok, drop;
  logic [7:0]  pl_data;
  logic [1:0]  err;

  tcp_rx_ctrl_if rx();

  tcp_rx_ctrl #(.LOCAL_PORT(16'd80), .MAX_OPT_BYTES(40)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .src_port(src_port), .dst_port(dst_port), .seq_num(seq_num), .ack_num(ack_num),
    .flags(flags), .window(window), .hdr_valid(hdr_valid), .pl_data(pl_data),
    .pl_valid(pl_valid), .done(done), .csum_ok(csum_ok), .drop(drop), .err(err)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         hdr_cnt = 0;
  logic [7:0] pl_log[$];
  done_t      done_log[$];
  logic [7:0] seg[$];

  // expectations from the model, plus bookkeeping from the most recent run
  logic       e_ok, e_drop, e_hdr;
  logic [1:0] e_err;
  logic [7:0] e_pl[$];
  int         last_pl0, last_dn0;
  done_t      d_last;

  // Observe events on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (hdr_valid) hdr_cnt++;
    if (pl_valid)  pl_log.push_back(pl_data);
    if (done)      done_log.push_back({csum_ok, drop, err});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ones-complement sum of seed and the first nb bytes taken as big-endian 16-bit words.
  function automatic logic [15:0] fold_sum(input logic [15:0] sd, input int nb);
    logic [31:0] s;
    logic [7:0]  lo;
    s = {16'd0, sd};
    for (int i = 0; i < nb; i += 2) begin
      lo = (i + 1 < nb) ? seg[i + 1] : 8'h00;
      s  = s + {16'd0, seg[i], lo};
    end
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  // Random header with given offset/port, options and payload; checksum made right or off by one.
  task automatic build(input int off, input int npl, input logic [15:0] dst, input bit fix,
                       input logic [15:0] sd);
    logic [15:0] ck;
    logic [8:0]  fl;
    int          nopt;
    seg.delete();
    fl = 9'($urandom);
    for (int i = 0; i < 20; i++) seg.push_back(8'($urandom));
    seg[2]  = dst[15:8];
    seg[3]  = dst[7:0];
    seg[12] = {4'(off), 3'b000, fl[8]};
    seg[13] = fl[7:0];
    seg[16] = 8'h00;
    seg[17] = 8'h00;
    nopt = (off > 5) ? off * 4 - 20 : 0;
    for (int i = 0; i < nopt + npl; i++) seg.push_back(8'($urandom));
    ck = ~fold_sum(sd, seg.size());
    if (!fix) ck = ck ^ 16'h0001;
    seg[16] = ck[15:8];
    seg[17] = ck[7:0];
  endtask

  // What the segment must produce, reasoned from byte counts and the header rules.
  task automatic model(input int nnib, input logic [15:0] sd);
    int          nb, hlen;
    logic [3:0]  off;
    logic [15:0] dst;
    logic [7:0]  b12;
    nb   = nnib / 2;
    b12  = (nb > 12) ? seg[12] : 8'h00;
    off  = b12[7:4];
    hlen = 4 * int'(off);
    dst  = (nb >= 4) ? {seg[2], seg[3]} : 16'h0000;
    e_ok = (fold_sum(sd, nb) == 16'hFFFF);
    if (nnib % 2 == 1)   e_err = 2'd3;
    else if (nb < 20)    e_err = 2'd1;
    else if (off < 4'd5) e_err = 2'd2;
    else if (nb < hlen)  e_err = 2'd1;
    else                 e_err = 2'd0;
    e_hdr  = (nb >= 20) && (off >= 4'd5) && (nb >= hlen);
    e_drop = (e_err != 2'd0) || !e_ok || (dst != 16'd80);
    e_pl.delete();
    if (e_hdr && dst == 16'd80)
      for (int i = hlen; i < nb; i++) e_pl.push_back(seg[i]);
  endtask

  task automatic send(input int nnib, input logic [15:0] sd, input int gap, input bit with_last);
    logic [7:0] b;
    rx.seed = sd;
    for (int k = 0; k < nnib; k++) begin
      b        = seg[k / 2];
      rx.valid = 1'b1;
      rx.din   = (k % 2 == 0) ? b[3:0] : b[7:4];
      rx.last  = with_last && (k == nnib - 1);
      @(posedge clk); #1;
      rx.valid = 1'b0;
      rx.last  = 1'b0;
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run(input string tag, input int nnib, input logic [15:0] sd, input int gap);
    int hv0;
    last_dn0 = done_log.size();
    last_pl0 = pl_log.size();
    hv0      = hdr_cnt;
    model(nnib, sd);
    send(nnib, sd, gap, 1'b1);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk({tag, ".done_cnt"}, done_log.size() - last_dn0, 1);
    d_last = (done_log.size() > last_dn0) ? done_log[last_dn0] : 4'b0000;
    chk({tag, ".csum_ok"}, d_last.ok, e_ok);
    chk({tag, ".drop"}, d_last.drop, e_drop);
    chk({tag, ".err"}, d_last.err, e_err);
    chk({tag, ".hdr_cnt"}, hdr_cnt - hv0, e_hdr ? 1 : 0);
    chk({tag, ".pl_cnt"}, pl_log.size() - last_pl0, e_pl.size());
    for (int i = 0; i < e_pl.size() && last_pl0 + i < pl_log.size(); i++)
      chk({tag, ".pl_data"}, pl_log[last_pl0 + i], e_pl[i]);
    if (e_hdr) begin
      chk({tag, ".ports"}, {src_port, dst_port}, {seg[0], seg[1], seg[2], seg[3]});
      chk({tag, ".seq"}, seq_num, {seg[4], seg[5], seg[6], seg[7]});
      chk({tag, ".ack"}, ack_num, {seg[8], seg[9], seg[10], seg[11]});
      chk({tag, ".flags_win"}, {7'd0, flags, window}, {7'd0, seg[12][0], seg[13], seg[14], seg[15]});
    end
  endtask

  task automatic load_syn();
    seg = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h50, 8'h02, 8'hFF, 8'hFF, 8'h9D, 8'h78, 8'h00, 8'h00};
  endtask

  initial begin
    int          off, npl, nnib, gap, dn0;
    logic [15:0] dst, sd, ck;
    bit          fix;

    rx.valid = 1'b0; rx.din = 4'd0; rx.last = 1'b0; rx.seed = 16'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ports", {src_port, dst_port}, 32'd0);
    chk("rst.seq_ack", seq_num | ack_num, 32'd0);
    chk("rst.flags_win", {7'd0, flags, window}, 32'd0);
    chk("rst.strobes", {hdr_valid, pl_valid, done, csum_ok, drop, err, pl_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // minimal SYN
    load_syn();
    run("syn", 40, 16'h0000, 0);
    chk("syn.seq_num", seq_num, 32'd1);
    chk("syn.flags", flags, 9'h002);
    chk("syn.verdict", {d_last.ok, d_last.drop, d_last.err}, 4'b1000);
    chk("syn.no_pl", pl_log.size() - last_pl0, 0);

    // same header, checksum off by one
    load_syn();
    seg[17] = 8'h79;
    run("badck", 40, 16'h0000, 0);
    chk("badck.verdict", {d_last.ok, d_last.drop}, 2'b01);

    // offset 6: MSS option then an odd-length payload
    load_syn();
    seg[12] = 8'h60;
    seg[16] = 8'h00;
    seg[17] = 8'h00;
    seg.push_back(8'h02); seg.push_back(8'h04); seg.push_back(8'h05); seg.push_back(8'hB4);
    seg.push_back(8'h41); seg.push_back(8'h42); seg.push_back(8'h43);
    ck = ~fold_sum(16'h1A2B, seg.size());
    seg[16] = ck[15:8];
    seg[17] = ck[7:0];
    run("opt", 2 * seg.size(), 16'h1A2B, 0);
    chk("opt.ok", d_last.ok, 1'b1);
    chk("opt.npl", pl_log.size() - last_pl0, 3);
    if (pl_log.size() - last_pl0 >= 3)
      chk("opt.bytes", {pl_log[last_pl0], pl_log[last_pl0 + 1], pl_log[last_pl0 + 2]}, 24'h414243);

    // wrong destination port with a good checksum and some payload
    build(5, 4, 16'h0051, 1'b1, 16'h0000);
    run("port", 2 * seg.size(), 16'h0000, 0);
    chk("port.verdict", {d_last.ok, d_last.drop, d_last.err}, 4'b1100);
    chk("port.no_pl", pl_log.size() - last_pl0, 0);

    // gapped stream truncated inside the header, then an odd nibble count
    load_syn();
    run("short", 22, 16'h0000, 3);
    chk("short.verdict", {d_last.drop, d_last.err}, 3'b101);
    load_syn();
    run("odd", 21, 16'h0000, 1);
    chk("odd.err", d_last.err, 2'd3);

    // reset at header byte 10 discards the segment; the next one passes
    load_syn();
    dn0 = done_log.size();
    send(20, 16'h0000, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst.fields", {src_port, dst_port}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("mid_rst.no_done", done_log.size() - dn0, 0);
    run("after_rst", 40, 16'h0000, 0);
    chk("after_rst.ok", {d_last.ok, d_last.drop}, 2'b10);

    // back-to-back: second segment starts in the done cycle of the first
    load_syn();
    dn0 = done_log.size();
    send(40, 16'h0000, 0, 1'b1);
    send(40, 16'h0000, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("b2b.done_cnt", done_log.size() - dn0, 2);
    if (done_log.size() >= dn0 + 2)
      chk("b2b.verdicts", {done_log[dn0], done_log[dn0 + 1]}, 8'b1000_1000);

    // randomized segments
    for (int t = 0; t < 40; t++) begin
      off  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 4)) : int'($urandom_range(5, 9));
      npl  = int'($urandom_range(0, 7));
      dst  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd80;
      fix  = ($urandom_range(0, 4) != 0);
      sd   = 16'($urandom);
      build(off, npl, dst, fix, sd);
      nnib = 2 * seg.size();
      if ($urandom_range(0, 4) == 0) nnib = int'($urandom_range(1, nnib));
      gap  = int'($urandom_range(0, 2));
      run("rnd", nnib, sd, gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
